// File: rtl/unpool.sv
// Nearest-neighbour unpooling: each accepted row vector is replayed as K output
// beats, each element repeated K times; disabled or K=1 gives a registered pass-through.
module unpool #(
   parameter int MAT_MUL_SIZE  = 8,
   parameter int DWIDTH        = 8,
   parameter int MAX_BITS_POOL = 3
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           enable_unpool,
   input  logic [MAX_BITS_POOL-1:0]       kernel_size,
   input  logic                           in_data_available,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
   output logic                           in_ready,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
   output logic                           out_data_available,
   output logic                           done_unpool,
   output logic                           overflow
);

   localparam int N    = MAT_MUL_SIZE;
   localparam int VW   = MAT_MUL_SIZE * DWIDTH;
   localparam int LOGN = $clog2(MAT_MUL_SIZE);

   typedef enum logic [0:0] {S_IDLE, S_EXPAND} state_t;

   state_t          state_q, state_d;
   logic [1:0]      beat_q, beat_d;      // index of the beat emitted at the next edge
   logic [1:0]      shift_q, shift_d;    // log2 of the effective K of the latched vector
   logic [VW-1:0]   data_q, data_d;
   logic [VW-1:0]   out_data_q, out_data_d;
   logic            avail_q, avail_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;

   logic [1:0]      shift_in;
   logic            last_beat;
   logic            accept;
   logic [VW-1:0]   sel_vec;
   logic [1:0]      sel_beat;
   logic [1:0]      sel_shift;
   logic [VW-1:0]   beat_vec;

   // Effective K: illegal sizes and the disabled mode both collapse to a single beat.
   always_comb begin
      shift_in = 2'd0;
      if (enable_unpool) begin
         case (kernel_size)
            MAX_BITS_POOL'(2): shift_in = 2'd1;
            MAX_BITS_POOL'(4): shift_in = 2'd2;
            default:           shift_in = 2'd0;
         endcase
      end
   end

   always_comb begin
      case (shift_q)
         2'd1:    last_beat = (beat_q == 2'd1);
         2'd2:    last_beat = (beat_q == 2'd3);
         default: last_beat = (beat_q == 2'd0);
      endcase
   end

   assign in_ready = (state_q == S_IDLE) || last_beat;
   assign accept   = in_data_available && in_ready;

   // From IDLE, beat 0 is built straight from the input so it lands one cycle after accept.
   assign sel_vec   = (state_q == S_IDLE) ? inp_data : data_q;
   assign sel_beat  = (state_q == S_IDLE) ? 2'd0     : beat_q;
   assign sel_shift = (state_q == S_IDLE) ? shift_in : shift_q;

   for (genvar gi = 0; gi < N; gi++) begin : g_elem
      localparam logic [LOGN-1:0] J = LOGN'(gi);
      logic [LOGN-1:0] idx;
      always_comb begin
         case (sel_shift)
            2'd1:    idx = (LOGN'(sel_beat[0]) << (LOGN - 1)) | (J >> 1);
            2'd2:    idx = (LOGN'(sel_beat) << (LOGN - 2)) | (J >> 2);
            default: idx = J;
         endcase
      end
      assign beat_vec[gi*DWIDTH +: DWIDTH] = sel_vec[idx*DWIDTH +: DWIDTH];
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      shift_d    = shift_q;
      data_d     = data_q;
      out_data_d = out_data_q;
      avail_d    = 1'b0;
      done_d     = 1'b0;
      ovf_d      = ovf_q | (in_data_available & ~in_ready);
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d     = inp_data;
               shift_d    = shift_in;
               out_data_d = beat_vec;
               avail_d    = 1'b1;
               if (shift_in != 2'd0) begin
                  state_d = S_EXPAND;
                  beat_d  = 2'd1;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         S_EXPAND: begin
            out_data_d = beat_vec;
            avail_d    = 1'b1;
            done_d     = last_beat;
            beat_d     = beat_q + 2'd1;
            if (last_beat) begin
               // A vector accepted on the last beat starts right after it; a
               // pass-through vector simply runs as a one-beat expansion.
               if (accept) begin
                  data_d  = inp_data;
                  shift_d = shift_in;
                  beat_d  = 2'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         beat_q     <= 2'd0;
         shift_q    <= 2'd0;
         data_q     <= '0;
         out_data_q <= '0;
         avail_q    <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         out_data_q <= out_data_d;
         avail_q    <= avail_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_data           = out_data_q;
   assign out_data_available = avail_q;
   assign done_unpool        = done_q;
   assign overflow           = ovf_q;

endmodule
